mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Sequential data-memory access controller for the 64-bit core's MEM stage. It sits directly downstream of the store mask/data generator. It accepts one load or store per request, with the byte-lane mask and lane-aligned write data already produced. It drives a valid/ready data-memory bus, waits for the response, and extracts and sign- or zero-extends load data. It stalls the pipeline for the whole transaction.

## Interface
Parameters:
- TIMEOUT, 256: maximum cycles spent in RESP before the access is aborted with an error; legal range 2..65536.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- req_valid  in  1  MEM stage presents a memory operation.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_width  in  3  width code: 000 none, 001 doubleword, 010 word, 011 half, 100 byte, 101 word unsigned, 110 half unsigned, 111 byte unsigned.
- req_mask  in  8  byte-lane write mask; used for stores only.
- req_wdata  in  64  lane-aligned store data.
- req_ready  out  1  unit can accept a request.
- stall  out  1  freeze upstream pipeline.
- bus_req_valid  out  1  bus request valid.
- bus_req_ready  in  1  bus accepts request.
- bus_addr  out  64  {req_addr[63:3], 3'b000}.
- bus_we  out  1  bus write enable.
- bus_mask  out  8  bus byte mask; all ones for loads.
- bus_wdata  out  64  bus write data.
- bus_resp_valid  in  1  bus response valid.
- bus_resp_data  in  64  read data; ignored for stores.
- bus_resp_ready  out  1  unit accepts a response.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done; the access timed out.
- rdata  out  64  extended load result; valid while done=1.

## Operation
- States:
  - IDLE: req_ready=1, bus_resp_ready=1. A response arriving in IDLE is a stale response and is discarded.
  - REQ: bus_req_valid=1.
  - RESP: bus_resp_ready=1, wait counter running.
  - DONE: done=1.
- IDLE, req_valid=1, req_width≠000: latch we, addr, width, mask, wdata; go to REQ.
- IDLE, req_valid=1, req_width=000: no-op. Go to DONE; rdata=0, err=0; no bus activity.
- REQ: bus outputs are driven from the latched values and held stable until bus_req_ready=1, then go to RESP. Clear the counter on entry to RESP.
- RESP, bus_resp_valid=1: capture the result into rdata and go to DONE. rdata is the load extraction for loads and 0 for stores.
- RESP, no response and counter = TIMEOUT-1: go to DONE with err=1, rdata=0.
- DONE: always returns to IDLE the next cycle. A new request can be accepted the cycle after DONE.
- Load extraction uses o = addr[2:0] of the latched address:
  - 001: rdata = data.
  - 010/101: word at bits [32*o[2] +: 32], sign- or zero-extended.
  - 011/110: half at bits [16*o[2:1] +: 16], sign- or zero-extended.
  - 100/111: byte at bits [8*o +: 8], sign- or zero-extended.
- Misalignment is not checked; low address bits below the access size are ignored.
- stall = (state==REQ) | (state==RESP) | (state==IDLE & req_valid & req_width≠000).
- Store width codes 101/110/111 behave identically to 010/011/100.

## Timing
- Reset (rstn=0 at a clock edge): state=IDLE, counter=0, and all latched fields cleared.
  - Outputs after reset: req_ready=1, bus_resp_ready=1. stall, bus_req_valid, bus_we, done and err are 0. bus_addr, bus_mask, bus_wdata and rdata are all 0.
- Reset mid-transaction: the transaction is abandoned with no done pulse. A late bus response is absorbed in IDLE.
- Minimum latency, request accepted at edge 0: REQ during cycle 1; RESP during cycle 2 with response present; done=1 during cycle 3.
- No-op latency: done during cycle 1.
- bus_resp_ready is 0 in REQ and DONE. A response is never accepted in the same cycle as the request handshake.
- rdata and err are registered. They hold their value after DONE until the next capture or reset.
- Counter width is clog2(TIMEOUT). Counter increments once per RESP cycle. err is asserted after exactly TIMEOUT RESP cycles without a response.

## Test plan
- Store word: addr 0x1004, width 010, mask 0xF0, wdata 0xDEADBEEF_00000000, bus_req_ready=1, response after 1 cycle -> bus_addr 0x1000, bus_mask 0xF0, bus_we=1; done in cycle 3; rdata 0; err 0.
- Signed byte load: addr 0x2003, width 100, resp_data 0x00000000_80000000 -> rdata 0xFFFFFFFF_FFFFFF80. Repeat with width 111 -> rdata 0x80.
- Unsigned half load: addr 0x2006, width 110, resp_data 0xBEEF0000_00000000 -> rdata 0xBEEF. With width 011 -> rdata 0xFFFFFFFF_FFFFBEEF.
- Backpressure: bus_req_ready low 4 cycles -> bus_addr, bus_mask and bus_wdata stable; stall=1 throughout; done 1 cycle after the response.
- Timeout: TIMEOUT=16, no response -> done=1 with err=1 exactly 16 cycles after entering RESP; rdata 0; next request is accepted normally.
- Reset in RESP, then the stale response arrives in IDLE, then a no-op request -> no done pulse for the aborted access; stale response discarded; no-op done after 1 cycle with rdata 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: one load/store per request over a
// valid/ready bus, with response timeout and load extraction/extension.
module mem_access_unit #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_width,
  input  logic [7:0]  req_mask,
  input  logic [63:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [63:0] bus_addr,
  output logic        bus_we,
  output logic [7:0]  bus_mask,
  output logic [63:0] bus_wdata,
  input  logic        bus_resp_valid,
  input  logic [63:0] bus_resp_data,
  output logic        bus_resp_ready,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t        r_state;
  logic          r_we;
  logic [63:0]   r_addr;
  logic [2:0]    r_width;
  logic [7:0]    r_mask;
  logic [63:0]   r_wdata;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic          r_err;
  logic [63:0]   r_rdata;
  logic          w_op;

  // Sub-size address bits select the lane; misalignment is deliberately ignored.
  function automatic logic [63:0] f_extract(input logic [2:0] w, input logic [2:0] o,
                                            input logic [63:0] d);
    logic        sgn;
    logic [31:0] wd;
    logic [15:0] hw;
    logic [7:0]  by;
    sgn = (w == 3'b010) | (w == 3'b011) | (w == 3'b100);
    wd  = d[{o[2], 5'b0} +: 32];
    hw  = d[{o[2:1], 4'b0} +: 16];
    by  = d[{o, 3'b0} +: 8];
    case (w)
      3'b001:         f_extract = d;
      3'b010, 3'b101: f_extract = {{32{sgn & wd[31]}}, wd};
      3'b011, 3'b110: f_extract = {{48{sgn & hw[15]}}, hw};
      3'b100, 3'b111: f_extract = {{56{sgn & by[7]}}, by};
      default:        f_extract = 64'd0;
    endcase
  endfunction

  assign w_op = req_valid & (req_width != 3'b000);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_width <= '0;
      r_mask  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_op) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_width <= req_width;
            r_mask  <= req_we ? req_mask : 8'hFF;
            r_wdata <= req_wdata;
            r_state <= S_REQ;
          end else if (req_valid) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
            r_rdata <= '0;
          end
        end
        S_REQ: begin
          if (bus_req_ready) begin
            r_cnt   <= '0;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus_resp_valid) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
            r_rdata <= r_we ? 64'd0 : f_extract(r_width, r_addr[2:0], bus_resp_data);
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = (r_state == S_IDLE);
  assign bus_resp_ready = (r_state == S_IDLE) | (r_state == S_RESP);
  assign bus_req_valid  = (r_state == S_REQ);
  assign stall          = (r_state == S_REQ) | (r_state == S_RESP) | ((r_state == S_IDLE) & w_op);
  assign bus_addr       = {r_addr[63:3], 3'b000};
  assign bus_we         = r_we;
  assign bus_mask       = r_mask;
  assign bus_wdata      = r_wdata;
  assign done           = r_done;
  assign err            = r_err;
  assign rdata          = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stimulus pushes expected completions into
// a scoreboard; a monitor pops and checks them on every done pulse.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [2:0]  req_width;
  logic [7:0]  req_mask;
  logic        req_ready, stall;
  logic        bus_req_valid, bus_req_ready;
  logic [63:0] bus_addr, bus_wdata;
  logic        bus_we;
  logic [7:0]  bus_mask;
  logic        bus_resp_valid, bus_resp_ready;
  logic [63:0] bus_resp_data;
  logic        done, err;
  logic [63:0] rdata;

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  typedef struct {
    logic [63:0] rd;
    logic        er;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_width(req_width), .req_mask(req_mask), .req_wdata(req_wdata),
    .req_ready(req_ready), .stall(stall),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_mask(bus_mask), .bus_wdata(bus_wdata),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
    .bus_resp_ready(bus_resp_ready),
    .done(done), .err(err), .rdata(rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (done) begin
      nvec++;
      if (sb.size() == 0) begin
        nmis++;
        $display("FAIL unexpected_done: cycle %0d rdata %h err %b, required no done", cyc, rdata, err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rdata !== e.rd || err !== e.er || cyc !== e.cyc) begin
          nmis++;
          $display("FAIL completion: rdata %h err %b cycle %0d, required rdata %h err %b cycle %0d",
                   rdata, err, cyc, e.rd, e.er, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic txn(input logic we, input logic [63:0] a, input logic [2:0] w,
                     input logic [7:0] m, input logic [63:0] wd, input int rdy_lat,
                     input int rsp_lat, input logic no_rsp, input logic [63:0] rd,
                     input logic [63:0] exp_rd, input logic exp_err);
    exp_t e;
    int   n;
    e.rd  = exp_rd;
    e.er  = exp_err;
    e.cyc = cyc + ((w == 3'b000) ? 1 : 2 + rdy_lat + (no_rsp ? 16 : rsp_lat + 1));
    sb.push_back(e);
    req_valid = 1'b1; req_we = we; req_addr = a; req_width = w; req_mask = m; req_wdata = wd;
    #1 chk("stall_accept", stall, (w != 3'b000));
    @(negedge clk);
    req_valid = 1'b0; req_addr = '1; req_wdata = '1; req_mask = '1;
    if (w != 3'b000) begin
      for (int i = 0; i <= rdy_lat; i++) begin
        chk("bus_req_valid", bus_req_valid, 1'b1);
        chk("bus_addr", bus_addr, {a[63:3], 3'b000});
        chk("bus_mask", bus_mask, we ? m : 8'hFF);
        chk("bus_wdata", bus_wdata, wd);
        chk("bus_we", bus_we, we);
        chk("stall_req", stall, 1'b1);
        chk("resp_ready_req", bus_resp_ready, 1'b0);
        bus_req_ready = (i == rdy_lat);
        @(negedge clk);
      end
      bus_req_ready = 1'b0;
      chk("stall_resp", stall, 1'b1);
      chk("resp_ready_resp", bus_resp_ready, 1'b1);
      if (!no_rsp) begin
        repeat (rsp_lat) @(negedge clk);
        bus_resp_valid = 1'b1; bus_resp_data = rd;
        @(negedge clk);
        bus_resp_valid = 1'b0; bus_resp_data = '0;
      end
    end
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      nvec++; nmis++;
      $display("FAIL done_timeout: no done within 40 cycles, required a done pulse");
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_width = '0;
    req_mask = '0; req_wdata = '0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
    bus_resp_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {req_ready, bus_resp_ready, stall, bus_req_valid, bus_we, done, err},
        7'b1100000);
    chk("reset_addr", bus_addr, 64'd0);
    chk("reset_mask", bus_mask, 8'd0);
    chk("reset_wdata", bus_wdata, 64'd0);
    chk("reset_rdata", rdata, 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    //  we  addr              w       mask   wdata                  rdy rsp nor resp_data              exp_rdata              err
    txn(1, 64'h1004, 3'b010, 8'hF0, 64'hDEADBEEF_00000000, 0, 0, 0, 64'h0,                 64'h0,                 0);
    txn(0, 64'h2003, 3'b100, 8'h00, 64'h0,                 0, 0, 0, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80, 0);
    txn(0, 64'h2003, 3'b111, 8'h00, 64'h0,                 0, 0, 0, 64'h00000000_80000000, 64'h00000000_00000080, 0);
    txn(0, 64'h2006, 3'b110, 8'h00, 64'h0,                 0, 0, 0, 64'hBEEF0000_00000000, 64'h00000000_0000BEEF, 0);
    txn(0, 64'h2006, 3'b011, 8'h00, 64'h0,                 0, 0, 0, 64'hBEEF0000_00000000, 64'hFFFFFFFF_FFFFBEEF, 0);
    txn(1, 64'h3008, 3'b001, 8'hFF, 64'h01234567_89ABCDEF, 4, 2, 0, 64'h0,                 64'h0,                 0);
    txn(0, 64'h300F, 3'b001, 8'h00, 64'h0,                 4, 0, 0, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF, 0);
    txn(0, 64'h4004, 3'b010, 8'h00, 64'h0,                 0, 1, 0, 64'h87654321_00000000, 64'hFFFFFFFF_87654321, 0);
    txn(0, 64'h4000, 3'b101, 8'h00, 64'h0,                 0, 0, 0, 64'h87654321_92345678, 64'h00000000_92345678, 0);
    txn(0, 64'h5000, 3'b010, 8'h00, 64'h0,                 0, 0, 1, 64'h0,                 64'h0,                 1);
    chk("err_hold", {63'd0, err}, 64'd1);
    txn(1, 64'h6002, 3'b011, 8'h0C, 64'h00000000_ABCD0000, 0, 0, 0, 64'h0,                 64'h0,                 0);
    txn(0, 64'h6001, 3'b100, 8'h00, 64'h0,                 0, 0, 0, 64'h00000000_00007F00, 64'h00000000_0000007F, 0);
    txn(0, 64'h7000, 3'b000, 8'h00, 64'h0,                 0, 0, 0, 64'h0,                 64'h0,                 0);

    // Abort a load in RESP, then feed it a stale response while idle.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h8005; req_width = 3'b100;
    @(negedge clk);
    req_valid = 1'b0;
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    chk("abort_in_resp", bus_resp_ready, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("abort_reset_ctl", {req_ready, stall, bus_req_valid, done}, 4'b1000);
    bus_resp_valid = 1'b1; bus_resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    bus_resp_valid = 1'b0; bus_resp_data = '0;
    chk("stale_discard_ctl", {req_ready, bus_req_valid, done}, 3'b100);
    chk("stale_discard_rdata", rdata, 64'd0);
    txn(0, 64'h9000, 3'b000, 8'h00, 64'h0, 0, 0, 0, 64'h0, 64'h0, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
